// File: rtl/pll_dvi_ctrl.sv
// Reset/lock sequencer and PSDA phase-step scheduler for the DVI rPLL.
// Runs entirely on the 27 MHz reference clock; PLL LOCK is synchronized before use.
module pll_dvi_ctrl #(
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned LOCK_STABLE   = 1024,
    parameter int unsigned MAX_RETRIES   = 7,
    parameter int unsigned SETTLE_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock_i,
    output logic       pll_reset_o,
    output logic [3:0] psda_o,
    input  logic       ps_req,
    input  logic [3:0] ps_val,
    output logic       ps_ack,
    output logic       dvi_rst_o,
    output logic       locked_o,
    output logic       fault_o,
    output logic [3:0] retry_cnt_o
);

    localparam int unsigned Max01 = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned Max23 = (LOCK_STABLE > SETTLE_CYCLES) ? LOCK_STABLE : SETTLE_CYCLES;
    localparam int unsigned MaxParam = (Max01 > Max23) ? Max01 : Max23;
    localparam int unsigned CntW = $clog2(MaxParam) + 1;

    localparam logic [CntW-1:0] RstEnd     = CntW'(RESET_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutEnd = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0] StableEnd  = CntW'(LOCK_STABLE - 1);
    localparam logic [CntW-1:0] SettleEnd  = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] CntMax     = {CntW{1'b1}};
    localparam logic [3:0]      MaxRetry   = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StResetPll,
        StWaitLock,
        StStable,
        StRun,
        StPhase,
        StFault
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      retry_q, retry_d;
    logic [3:0]      psda_q, psda_d;
    logic            ack_q, ack_d;
    logic            lock_meta_q, lock_s_q;
    logic [3:0]      retry_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= StResetPll;
            cnt_q       <= '0;
            retry_q     <= '0;
            psda_q      <= '0;
            ack_q       <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock_i;
            lock_s_q    <= lock_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            psda_q      <= psda_d;
            ack_q       <= ack_d;
        end
    end

    assign retry_inc = (retry_q == MaxRetry) ? retry_q : retry_q + 4'd1;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        psda_d  = psda_q;
        ack_d   = 1'b0;
        unique case (state_q)
            StResetPll: begin
                if (cnt_q == RstEnd) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (lock_s_q) begin
                    state_d = StStable;
                end else if (cnt_q == TimeoutEnd) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == MaxRetry) ? StFault : StResetPll;
                end
            end
            StStable: begin
                // A dropout restarts qualification but is not a failed attempt.
                if (!lock_s_q) begin
                    state_d = StWaitLock;
                end else if (cnt_q == StableEnd) begin
                    state_d = StRun;
                    retry_d = '0;
                end
            end
            StRun: begin
                // ack_q blocks re-accepting the request that was just acknowledged.
                if (!lock_s_q) begin
                    state_d = StResetPll;
                end else if (ps_req && !ack_q) begin
                    psda_d  = ps_val;
                    state_d = StPhase;
                end
            end
            StPhase: begin
                if (!lock_s_q) begin
                    state_d = StResetPll;
                end else if (cnt_q == SettleEnd) begin
                    ack_d   = 1'b1;
                    state_d = StRun;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StResetPll;
            end
        endcase
    end

    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign pll_reset_o = (state_q == StResetPll) || (state_q == StFault);
    assign locked_o    = (state_q == StRun) || (state_q == StPhase);
    assign dvi_rst_o   = !locked_o;
    assign fault_o     = (state_q == StFault);
    assign retry_cnt_o = retry_q;
    assign psda_o      = psda_q;
    assign ps_ack      = ack_q;

endmodule
